// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller:
// scan state encoding, the active-low hex segment table and the all-off pattern.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } state_t;

    // Active-low segment patterns for hex 0..F, bit order g..a.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // dp plus all seven segments dark.
    localparam logic [7:0] SEG_OFF = 8'hFF;

endpackage

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low g..a segment lookup.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Plain table lookup; one instance serves every digit through the scan mux.
    assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a common-anode
// seven-segment display. Each digit slot is BLANK_CYCLES of all-off followed
// by SCAN_CYCLES lit; displayed data is double-buffered and only changes at
// frame boundaries (entry into BLANK for digit 0).
//
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (all higher nibbles also zero) are shown
//   dark; digit 0 is always shown.
//
// load handshake: load is a one-cycle strobe with no back-pressure; every
// cycle it is high is accepted, and the last load before a boundary wins.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_n_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic                    load_pending,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [7:0]              seg_n,
    output logic                    frame_tick
);
    import seg7_pkg::*;

    localparam int DW   = 4 * NUM_DIGITS;
    localparam int CMAX = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
    localparam int CW   = ($clog2(CMAX) > 0) ? $clog2(CMAX) : 1;
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // FSM and counters
    state_t          state, state_n;
    logic [IW-1:0]   idx, idx_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            started;
    logic            boundary;

    // Buffers
    logic [DW-1:0]         shadow_data, shadow_data_n;
    logic [NUM_DIGITS-1:0] shadow_dp, shadow_dp_n;
    logic [DW-1:0]         pend_data, pend_data_n;
    logic [NUM_DIGITS-1:0] pend_dp, pend_dp_n;
    logic                  load_pending_n;
    logic                  bypass;

    // Output next values
    logic [NUM_DIGITS-1:0] an_n_n;
    logic [7:0]            seg_n_n;
    logic [3:0]            cur_nibble;
    logic [6:0]            dec_seg;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_mask, blank_mask_n;
    logic                  commit;

    // Digit i is dark when it and every higher nibble are zero; digit 0 never is.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DW-1:0] d);
        logic [NUM_DIGITS-1:0] m;
        logic                  zero_above;
        zero_above = 1'b1;
        m = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (d[4*i +: 4] == 4'h0);
            m[i] = zero_above;
        end
        m[0] = 1'b0;
        return m;
    endfunction
`endif

    // Single decoder on the nibble of the digit about to be shown.
    assign cur_nibble = shadow_data_n[{idx_n, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nibble (cur_nibble),
        .seg_n  (dec_seg)
    );

    // Scan sequencing: BLANK then SCAN per digit; the very first clock after
    // reset counts as a frame boundary without advancing the counter.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        cnt_n    = cnt;
        boundary = 1'b0;
        if (!started) begin
            boundary = 1'b1;
        end else begin
            case (state)
                BLANK: begin
                    if (cnt == CW'(BLANK_CYCLES - 1)) begin
                        state_n = SCAN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                SCAN: begin
                    if (cnt == CW'(SCAN_CYCLES - 1)) begin
                        state_n = BLANK;
                        cnt_n   = '0;
                        if (idx == IW'(NUM_DIGITS - 1)) begin
                            idx_n    = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_n = idx + IW'(1);
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = BLANK;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Buffering: pending commits at the boundary; a load landing on the
    // boundary edge or during the frame_tick cycle goes straight to shadow.
    always_comb begin
        shadow_data_n  = shadow_data;
        shadow_dp_n    = shadow_dp;
        pend_data_n    = pend_data;
        pend_dp_n      = pend_dp;
        load_pending_n = load_pending;
        bypass         = boundary || frame_tick;
        if (boundary && load_pending) begin
            shadow_data_n  = pend_data;
            shadow_dp_n    = pend_dp;
            load_pending_n = 1'b0;
        end
        if (load) begin
            if (bypass) begin
                shadow_data_n  = data_in;
                shadow_dp_n    = dp_n_in;
                load_pending_n = 1'b0;
            end else begin
                pend_data_n    = data_in;
                pend_dp_n      = dp_n_in;
                load_pending_n = 1'b1;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign commit       = (boundary && load_pending) || (load && bypass);
    assign blank_mask_n = commit ? lz_mask(shadow_data_n) : blank_mask;
`endif

    // Output values for the state being entered, so outputs track the FSM edge.
    always_comb begin
        an_n_n  = '1;
        seg_n_n = SEG_OFF;
        if (state_n == SCAN) begin
            an_n_n[idx_n] = ~digit_en[idx_n];
            seg_n_n       = {shadow_dp_n[idx_n], dec_seg};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (blank_mask_n[idx_n]) begin
                seg_n_n = SEG_OFF;
            end
`endif
        end
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BLANK;
            idx          <= '0;
            cnt          <= '0;
            started      <= 1'b0;
            shadow_data  <= '0;
            shadow_dp    <= '1;
            pend_data    <= '0;
            pend_dp      <= '1;
            load_pending <= 1'b0;
            frame_tick   <= 1'b0;
            an_n         <= '1;
            seg_n        <= SEG_OFF;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            cnt          <= cnt_n;
            started      <= 1'b1;
            shadow_data  <= shadow_data_n;
            shadow_dp    <= shadow_dp_n;
            pend_data    <= pend_data_n;
            pend_dp      <= pend_dp_n;
            load_pending <= load_pending_n;
            frame_tick   <= boundary;
            an_n         <= an_n_n;
            seg_n        <= seg_n_n;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Blank mask follows the shadow word; it only moves on a commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_mask <= ~NUM_DIGITS'(1);
        end else begin
            blank_mask <= blank_mask_n;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl with SCAN_CYCLES=4, BLANK_CYCLES=2, 8 digits.
// The reference model tracks position within the frame as a plain cycle
// number and derives the expected display from it every clock.
module tb_seg7_scan_ctrl;

  localparam int N     = 8;
  localparam int S     = 4;
  localparam int B     = 2;
  localparam int P     = S + B;
  localparam int FRAME = N * P;

  logic            clk;
  logic            rst_n;
  logic [4*N-1:0]  data_in;
  logic [N-1:0]    dp_n_in;
  logic [N-1:0]    digit_en;
  logic            load;
  logic            load_pending;
  logic [N-1:0]    an_n;
  logic [7:0]      seg_n;
  logic            frame_tick;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit              m_started;
  int              t;
  logic [4*N-1:0]  m_shadow, m_pend;
  logic [N-1:0]    m_sdp, m_pdp;
  logic            m_lp, m_tick;
  logic [N-1:0]    exp_an;
  logic [7:0]      exp_seg;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg7_scan_ctrl #(
    .NUM_DIGITS   (N),
    .SCAN_CYCLES  (S),
    .BLANK_CYCLES (B)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .dp_n_in      (dp_n_in),
    .digit_en     (digit_en),
    .load         (load),
    .load_pending (load_pending),
    .an_n         (an_n),
    .seg_n        (seg_n),
    .frame_tick   (frame_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h at %0t (frame pos %0d)", tag, got, exp, $time, t);
    end
  endtask

  function automatic bit is_blanked(int i, logic [4*N-1:0] d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    return (i != 0) && ((d >> (4 * i)) == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_started = 1'b0;
    t         = 0;
    m_shadow  = '0;
    m_sdp     = '1;
    m_pend    = '0;
    m_pdp     = '1;
    m_lp      = 1'b0;
    m_tick    = 1'b0;
  endtask

  // Advance the model by one clock using the inputs as currently driven.
  task automatic model_edge();
    bit boundary;
    int d;
    if (!m_started) begin
      m_started = 1'b1;
      t = 0;
    end else begin
      t = (t + 1) % FRAME;
    end
    boundary = (t == 0);
    if (boundary && m_lp) begin
      m_shadow = m_pend;
      m_sdp    = m_pdp;
      m_lp     = 1'b0;
    end
    if (load) begin
      if (boundary || m_tick) begin
        m_shadow = data_in;
        m_sdp    = dp_n_in;
      end else begin
        m_pend = data_in;
        m_pdp  = dp_n_in;
        m_lp   = 1'b1;
      end
    end
    m_tick  = boundary;
    exp_an  = '1;
    exp_seg = 8'hFF;
    if ((t % P) >= B) begin
      d = t / P;
      exp_an[d] = ~digit_en[d];
      if (!is_blanked(d, m_shadow))
        exp_seg = {m_sdp[d], seg_tab[m_shadow[4*d +: 4]]};
    end
  endtask

  // driver: one clock with full output comparison; load is a single-cycle pulse
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    load = 1'b0;
    check_eq("frame_tick", frame_tick, m_tick);
    check_eq("an_n", an_n, exp_an);
    check_eq("seg_n", seg_n, exp_seg);
    check_eq("load_pending", load_pending, m_lp);
  endtask

  // run until the model sits at frame position pos (bounded)
  task automatic run_to(input int pos);
    int n;
    n = 0;
    step();
    while (t != pos && n < 2 * FRAME) begin
      step();
      n++;
    end
    check_eq("run_to_reached", t, pos);
  endtask

  task automatic random_phase(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        load    = 1'b1;
        data_in = $urandom >> $urandom_range(0, 31);
        dp_n_in = N'($urandom);
      end
      if ($urandom_range(0, 7) == 0) digit_en = N'($urandom);
      step();
    end
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    load     = 1'b0;
    data_in  = '0;
    dp_n_in  = '1;
    digit_en = '1;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_an_n", an_n, 8'hFF);
    check_eq("rst_seg_n", seg_n, 8'hFF);
    check_eq("rst_frame_tick", frame_tick, 1'b0);
    check_eq("rst_load_pending", load_pending, 1'b0);
    rst_n = 1'b1;

    // first cycle after release is a frame boundary, digit 0 shows 0
    step();
    check_eq("first_tick", frame_tick, 1'b1);
    run_to(B);
    check_eq("first_dig0_an", an_n, 8'hFE);
    check_eq("first_dig0_seg", seg_n, 8'hC0);
    run_to(P + B);
    check_eq("first_dig1_an", an_n, 8'hFD);

    // mid-frame load waits for the next boundary
    run_to(20);
    data_in = 32'h0000_00A5;
    dp_n_in = 8'hFE;
    load    = 1'b1;
    step();
    check_eq("pending_set", load_pending, 1'b1);
    run_to(B);
    check_eq("a5_dig0", seg_n, 8'h12);
    check_eq("a5_pending_clear", load_pending, 1'b0);
    run_to(P + B);
    check_eq("a5_dig1", seg_n, 8'h88);

    // load during the frame_tick cycle is committed at once
    run_to(0);
    data_in = 32'h0000_0001;
    dp_n_in = 8'hFF;
    load    = 1'b1;
    step();
    check_eq("bypass_no_pending", load_pending, 1'b0);
    run_to(B);
    check_eq("bypass_dig0", seg_n, 8'hF9);

    // only digit 0 enabled; frame length unchanged
    digit_en = 8'h01;
    run_to(0);
    n = 0;
    step();
    n++;
    while (frame_tick !== 1'b1 && n < 4 * FRAME) begin
      step();
      n++;
    end
    check_eq("frame_len", n, FRAME);

    // randomized traffic
    random_phase(1200);

    // leading-zero pattern
    digit_en = '1;
    data_in  = 32'h0000_0100;
    dp_n_in  = 8'hFF;
    load     = 1'b1;
    run_to(0);
    run_to(B);
    check_eq("lz_dig0", seg_n, 8'hC0);
    run_to(P + B);
    check_eq("lz_dig1", seg_n, 8'hC0);
    run_to(2 * P + B);
    check_eq("lz_dig2", seg_n, 8'hF9);
    run_to(3 * P + B);
    check_eq("lz_dig3_an", an_n, 8'hF7);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    check_eq("lz_dig3", seg_n, 8'hFF);
`else
    check_eq("lz_dig3", seg_n, 8'hC0);
`endif

    // asynchronous reset during the scan of digit 5
    data_in = 32'h8765_4321;
    dp_n_in = 8'h00;
    load    = 1'b1;
    run_to(0);
    run_to(5 * P + B + 1);
    check_eq("pre_rst_an", an_n, 8'hDF);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_an_n", an_n, 8'hFF);
    check_eq("async_seg_n", seg_n, 8'hFF);
    check_eq("async_tick", frame_tick, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check_eq("restart_tick", frame_tick, 1'b1);
    run_to(B);
    check_eq("restart_dig0_an", an_n, 8'hFE);
    check_eq("restart_dig0_seg", seg_n, 8'hC0);
    run_to(5 * P + B);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    check_eq("restart_dig5_seg", seg_n, 8'hFF);
`else
    check_eq("restart_dig5_seg", seg_n, 8'hC0);
`endif
    random_phase(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
